arp_rx: RTL and testbench
=========================

Name: arp_rx

Overview:
- Upstream stage of the ARP controller: parses the GMII receive byte stream and recognises ARP request/reply frames addressed to this board.
- Reports each accepted frame with a one-cycle `arp_rx_done` pulse, the opcode, and the sender MAC/IP.
- The controller uses these to schedule a reply; the transmitter uses them as the destination addresses.

Parameters:
- BOARD_MAC, 48'h00_11_22_33_44_55, local MAC; destination filter, alongside broadcast FF:FF:FF:FF:FF:FF.
- BOARD_IP, 32'hC0_A8_01_0A, local IPv4 (192.168.1.10); must equal the ARP target protocol address (TPA).

Ports:
- clk  input  1  GMII rx clock (125 MHz); all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gmii_rx_dv  input  1  receive data valid.
- gmii_rxd  input  8  receive byte.
- arp_rx_done  output  1  one-cycle pulse: valid ARP frame accepted.
- arp_rx_op  output  1  1 = request (OPER 1), 0 = reply (OPER 2).
- src_mac  output  48  sender hardware address (SHA) of last accepted frame.
- src_ip  output  32  sender protocol address (SPA) of last accepted frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0, dv_d = 1.
- dv_d is the registered `gmii_rx_dv`. Because it resets to 1, a frame already in flight when reset releases is ignored.
- States: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END. Each state consumes one byte per cycle while dv = 1.
- IDLE:
  - Leave only on a dv rising edge (dv = 1, dv_d = 0) with rxd = 0x55.
  - Go to PREAMBLE with cnt = 1.
- PREAMBLE:
  - rxd = 0x55 and cnt < 7: increment cnt.
  - rxd = 0xD5 and cnt = 7: go to ETH_HEAD, cnt = 0.
  - Any other byte: go to RX_END.
- ETH_HEAD: 14 bytes.
  - Bytes 0-5 (destination MAC) must all equal BOARD_MAC, or all equal 0xFF.
  - Bytes 6-11 are ignored.
  - Bytes 12-13 must be 0x08, 0x06.
  - Any mismatch: go to RX_END at that byte.
- ARP_DATA: 28 bytes, checked in this order.
  - HTYPE = 0x0001.
  - PTYPE = 0x0800.
  - HLEN = 0x06, PLEN = 0x04.
  - OPER = 0x0001 or 0x0002.
  - SHA (6 bytes) and SPA (4 bytes) are shifted into internal capture registers, MSB first.
  - THA (6 bytes) is ignored.
  - TPA (4 bytes) must equal BOARD_IP.
  - Any mismatch: go to RX_END.
- Commit (CRC feature out):
  - In the cycle after TPA byte 3 is sampled: `arp_rx_done` = 1 for exactly one cycle.
  - In that same cycle, `arp_rx_op`, `src_mac` and `src_ip` update from the capture registers.
  - Then go to RX_END.
  - Outputs hold their values until the next commit. A rejected frame never changes them.
- RX_END: wait for dv = 0, then go to IDLE.
- dv = 0 in any state before the commit: go to IDLE with no pulse and outputs unchanged. This covers truncated frames.
- Back-to-back frames: the one-cycle dv-low gap is enough. IDLE sees the next rising edge.
- Padding and FCS bytes after TPA are consumed in RX_END.

Optional Feature:
- Macro: ARP_RX_CRC_EN.
- Defined:
  - CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte-wide, LSB first) runs over every byte from the first destination-MAC byte through the last FCS byte.
  - The commit is deferred. After TPA passes, the FSM stays in RX_END while the CRC keeps running.
  - On the first dv = 0 cycle, the CRC register is compared with the residue 0xDEBB20E3.
  - Match: `arp_rx_done` pulses in the next cycle, and outputs update in that cycle.
  - Mismatch: no pulse, outputs unchanged.
  - CRC reinitialises on every SFD.
- Undefined: no CRC logic; commit timing is exactly as in Behaviour.

Test Plan:
- Broadcast request: dest FF×6, OPER 1, SHA 02:00:00:00:00:01, SPA C0A80102, TPA C0A8010A. Required: one `arp_rx_done` pulse; `arp_rx_op` = 1; `src_mac` = 48'h020000000001; `src_ip` = 32'hC0A80102.
- Unicast reply: dest 00:11:22:33:44:55, OPER 2, SHA 02:00:00:00:00:02, SPA C0A80103. Required: pulse; `arp_rx_op` = 0; `src_ip` = 32'hC0A80103.
- Rejected frames, each with outputs unchanged from the previous frame and no pulse:
  - TPA = C0A8010B.
  - Ethertype 0x0800.
  - OPER 3.
  - Dest 00:11:22:33:44:56.
- Truncation: dv drops after SPA byte 2 → no pulse, FSM in IDLE; an immediate valid frame after a one-cycle gap → pulse.
- Reset: assert `rst_n` low mid-SHA, release while dv = 1 → remainder of that frame ignored, outputs 0; next frame accepted.
- ARP_RX_CRC_EN defined:
  - Correct FCS → pulse exactly 1 cycle after dv falls.
  - One FCS bit flipped → no pulse.
  - Without the macro, the same valid frame pulses 1 cycle after TPA byte 3.

Source files
------------

// File: rtl/arp_rx.sv
// arp_rx: parses the GMII receive stream and reports ARP request/reply frames addressed to this board.
// Define ARP_RX_CRC_EN to hold the commit until the frame FCS has been verified.
module arp_rx #(
   parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
   parameter logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic        arp_rx_done,
   output logic        arp_rx_op,
   output logic [47:0] src_mac,
   output logic [31:0] src_ip
);
   typedef enum logic [2:0] {IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg, cnt_next;
   logic        dv_d_reg;
   logic        mac_ok_reg, mac_ok_next;
   logic        bc_ok_reg, bc_ok_next;
   logic        op_cap_reg, op_cap_next;
   logic [47:0] sha_cap_reg, sha_cap_next;
   logic [31:0] spa_cap_reg, spa_cap_next;
   logic        commit;
   logic        done_reg, op_reg;
   logic [47:0] mac_reg;
   logic [31:0] ip_reg;
   logic [7:0]  mac_byte, ip_byte;
   logic        mac_hit, bc_hit;

`ifdef ARP_RX_CRC_EN
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   logic [31:0] crc_reg, crc_next;
   logic        tpa_ok_reg, tpa_ok_next;

   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction
`endif

   // Expected byte of the local MAC (dest bytes 0-5) and IP (TPA bytes 0-3), MSB first.
   assign mac_byte = 8'(BOARD_MAC >> {(3'd5 - cnt_reg[2:0]), 3'b000});
   assign ip_byte  = 8'(BOARD_IP >> {(2'd3 - cnt_reg[1:0]), 3'b000});
   assign mac_hit  = mac_ok_reg && (gmii_rxd == mac_byte);
   assign bc_hit   = bc_ok_reg && (gmii_rxd == 8'hFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         dv_d_reg    <= 1'b1;
         mac_ok_reg  <= 1'b0;
         bc_ok_reg   <= 1'b0;
         op_cap_reg  <= 1'b0;
         sha_cap_reg <= '0;
         spa_cap_reg <= '0;
         done_reg    <= 1'b0;
         op_reg      <= 1'b0;
         mac_reg     <= '0;
         ip_reg      <= '0;
`ifdef ARP_RX_CRC_EN
         crc_reg     <= '1;
         tpa_ok_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         dv_d_reg    <= gmii_rx_dv;
         mac_ok_reg  <= mac_ok_next;
         bc_ok_reg   <= bc_ok_next;
         op_cap_reg  <= op_cap_next;
         sha_cap_reg <= sha_cap_next;
         spa_cap_reg <= spa_cap_next;
         done_reg    <= commit;
         if (commit) begin
            op_reg  <= op_cap_reg;
            mac_reg <= sha_cap_reg;
            ip_reg  <= spa_cap_reg;
         end
`ifdef ARP_RX_CRC_EN
         crc_reg     <= crc_next;
         tpa_ok_reg  <= tpa_ok_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      mac_ok_next  = mac_ok_reg;
      bc_ok_next   = bc_ok_reg;
      op_cap_next  = op_cap_reg;
      sha_cap_next = sha_cap_reg;
      spa_cap_next = spa_cap_reg;
      commit       = 1'b0;
`ifdef ARP_RX_CRC_EN
      crc_next     = crc_reg;
      tpa_ok_next  = tpa_ok_reg;
`endif
      if (state_reg != IDLE && !gmii_rx_dv) begin
         // End of frame (or truncation): only a fully checked frame may commit here.
         state_next = IDLE;
`ifdef ARP_RX_CRC_EN
         commit      = (state_reg == RX_END) && tpa_ok_reg && (crc_reg == CRC_RESIDUE);
         tpa_ok_next = 1'b0;
`endif
      end else begin
`ifdef ARP_RX_CRC_EN
         if (gmii_rx_dv && (state_reg inside {ETH_HEAD, ARP_DATA, RX_END}))
            crc_next = crc_byte(crc_reg, gmii_rxd);
`endif
         case (state_reg)
            IDLE: begin
               if (gmii_rx_dv && !dv_d_reg && gmii_rxd == 8'h55) begin
                  state_next = PREAMBLE;
                  cnt_next   = 5'd1;
               end
            end
            PREAMBLE: begin
               if (gmii_rxd == 8'h55 && cnt_reg < 5'd7) begin
                  cnt_next = cnt_reg + 5'd1;
               end else if (gmii_rxd == 8'hD5 && cnt_reg == 5'd7) begin
                  state_next  = ETH_HEAD;
                  cnt_next    = 5'd0;
                  mac_ok_next = 1'b1;
                  bc_ok_next  = 1'b1;
`ifdef ARP_RX_CRC_EN
                  crc_next    = '1;
                  tpa_ok_next = 1'b0;
`endif
               end else begin
                  state_next = RX_END;
               end
            end
            ETH_HEAD: begin
               cnt_next = cnt_reg + 5'd1;
               if (cnt_reg < 5'd6) begin
                  mac_ok_next = mac_hit;
                  bc_ok_next  = bc_hit;
                  if (!mac_hit && !bc_hit) state_next = RX_END;
               end else if (cnt_reg == 5'd12) begin
                  if (gmii_rxd != 8'h08) state_next = RX_END;
               end else if (cnt_reg == 5'd13) begin
                  if (gmii_rxd == 8'h06) begin
                     state_next = ARP_DATA;
                     cnt_next   = 5'd0;
                  end else begin
                     state_next = RX_END;
                  end
               end
            end
            ARP_DATA: begin
               cnt_next = cnt_reg + 5'd1;
               case (cnt_reg) inside
                  5'd0, 5'd3, 5'd6: if (gmii_rxd != 8'h00) state_next = RX_END;
                  5'd1: if (gmii_rxd != 8'h01) state_next = RX_END;
                  5'd2: if (gmii_rxd != 8'h08) state_next = RX_END;
                  5'd4: if (gmii_rxd != 8'h06) state_next = RX_END;
                  5'd5: if (gmii_rxd != 8'h04) state_next = RX_END;
                  5'd7: begin
                     if (gmii_rxd == 8'h01 || gmii_rxd == 8'h02) op_cap_next = (gmii_rxd == 8'h01);
                     else state_next = RX_END;
                  end
                  [5'd8:5'd13]:  sha_cap_next = {sha_cap_reg[39:0], gmii_rxd};
                  [5'd14:5'd17]: spa_cap_next = {spa_cap_reg[23:0], gmii_rxd};
                  [5'd24:5'd27]: begin
                     if (gmii_rxd != ip_byte) begin
                        state_next = RX_END;
                     end else if (cnt_reg == 5'd27) begin
                        state_next = RX_END;
`ifdef ARP_RX_CRC_EN
                        tpa_ok_next = 1'b1;
`else
                        commit = 1'b1;
`endif
                     end
                  end
                  default: ;
               endcase
            end
            RX_END: ;
            default: state_next = IDLE;
         endcase
      end
   end

   assign arp_rx_done = done_reg;
   assign arp_rx_op   = op_reg;
   assign src_mac     = mac_reg;
   assign src_ip      = ip_reg;
endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: directed and randomized ARP frames checked against a field-level frame acceptance model.
// Follows ARP_RX_CRC_EN to choose the expected commit point and FCS rule.
module tb_arp_rx;
   localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
   localparam logic [31:0] BOARD_IP  = 32'hC0_A8_01_0A;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gmii_rx_dv = 1'b0;
   logic [7:0]  gmii_rxd = 8'h00;
   logic        arp_rx_done, arp_rx_op;
   logic [47:0] src_mac;
   logic [31:0] src_ip;

   int          checks = 0;
   int          errors = 0;
   longint      cyc = 0;
   longint      pulses[$];
   logic [7:0]  frm[$];
   logic        exp_op = 1'b0;
   logic [47:0] exp_mac = '0;
   logic [31:0] exp_ip = '0;

   arp_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
      .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
      .arp_rx_done(arp_rx_done), .arp_rx_op(arp_rx_op), .src_mac(src_mac), .src_ip(src_ip)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (arp_rx_done === 1'b1) pulses.push_back(cyc);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_over(input int lo, input int hi);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = lo; i <= hi; i++) begin
         c ^= {24'd0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   // Frame layout: 8 preamble/SFD, 14 Ethernet header, 28 ARP, 18 padding, then 4 FCS.
   task automatic build(input logic [47:0] dest, input logic [47:0] sha, input logic [31:0] spa,
                        input logic [15:0] oper, input logic [31:0] tpa);
      frm.delete();
      repeat (7) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) frm.push_back(dest[8*i +: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
      frm.push_back(8'h08); frm.push_back(8'h06);
      frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h08); frm.push_back(8'h00);
      frm.push_back(8'h06); frm.push_back(8'h04);
      frm.push_back(oper[15:8]); frm.push_back(oper[7:0]);
      for (int i = 5; i >= 0; i--) frm.push_back(sha[8*i +: 8]);
      for (int i = 3; i >= 0; i--) frm.push_back(spa[8*i +: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
      for (int i = 3; i >= 0; i--) frm.push_back(tpa[8*i +: 8]);
      repeat (18) frm.push_back(8'($urandom));
   endtask

   task automatic add_fcs(input bit flip);
      logic [31:0] fcs;
      fcs = ~crc_over(8, frm.size() - 1);
      if (flip) fcs[$urandom_range(31, 0)] ^= 1'b1;
      for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
   endtask

   function automatic bit model_accept(input int n);
      bit bc = 1'b1;
      bit uc = 1'b1;
      if (n < 50) return 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (frm[8+i] != 8'hFF) bc = 1'b0;
         if (frm[8+i] != BOARD_MAC[8*(5-i) +: 8]) uc = 1'b0;
      end
      if (!(bc || uc)) return 1'b0;
      if ({frm[20], frm[21]} != 16'h0806) return 1'b0;
      if ({frm[22], frm[23], frm[24], frm[25], frm[26], frm[27]} != 48'h0001_0800_0604) return 1'b0;
      if ({frm[28], frm[29]} != 16'h0001 && {frm[28], frm[29]} != 16'h0002) return 1'b0;
      if ({frm[46], frm[47], frm[48], frm[49]} != BOARD_IP) return 1'b0;
`ifdef ARP_RX_CRC_EN
      if (n != frm.size()) return 1'b0;
      if (~crc_over(8, n - 5) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]}) return 1'b0;
`endif
      return 1'b1;
   endfunction

   // Drives the first n bytes, then one dv-low cycle; reports the cycles at which TPA byte 3 and dv-low are sampled.
   task automatic send(input int n, output longint tpa_cyc, output longint end_cyc);
      tpa_cyc = -1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         gmii_rx_dv = 1'b1;
         gmii_rxd   = frm[i];
         if (i == 49) tpa_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0;
      gmii_rxd   = 8'h00;
      end_cyc    = cyc + 1;
   endtask

   task automatic run_frame(input string name, input int n, input int idle);
      longint tpa_cyc, end_cyc, exp_cyc;
      bit     acc;
      acc = model_accept(n);
      pulses.delete();
      send(n, tpa_cyc, end_cyc);
      repeat (idle) @(posedge clk);
      if (idle > 0) #1;
`ifdef ARP_RX_CRC_EN
      exp_cyc = end_cyc;
`else
      exp_cyc = tpa_cyc;
`endif
      if (acc) begin
         exp_op  = (frm[29] == 8'h01);
         exp_mac = {frm[30], frm[31], frm[32], frm[33], frm[34], frm[35]};
         exp_ip  = {frm[36], frm[37], frm[38], frm[39]};
      end
      check({name, " pulses"}, 64'(pulses.size()), acc ? 64'd1 : 64'd0);
      if (acc && pulses.size() == 1) check({name, " timing"}, 64'(pulses[0]), 64'(exp_cyc));
      check({name, " op"}, 64'(arp_rx_op), 64'(exp_op));
      check({name, " mac"}, 64'(src_mac), 64'(exp_mac));
      check({name, " ip"}, 64'(src_ip), 64'(exp_ip));
      $display("frame %s: bytes=%0d accept=%0b pulses=%0d op=%0b mac=%h ip=%h",
               name, n, acc, pulses.size(), arp_rx_op, src_mac, src_ip);
   endtask

   initial begin
      logic [47:0] sha;
      logic [31:0] spa;
      int          v;

      repeat (3) @(posedge clk);
      #1;
      check("reset done", 64'(arp_rx_done), 64'd0);
      check("reset op", 64'(arp_rx_op), 64'd0);
      check("reset mac", 64'(src_mac), 64'd0);
      check("reset ip", 64'(src_ip), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      build('1, 48'h020000000001, 32'hC0A80102, 16'h0001, BOARD_IP); add_fcs(1'b0);
      run_frame("bcast_req", frm.size(), 4);
      check("bcast_req mac const", 64'(src_mac), 64'h020000000001);
      check("bcast_req ip const", 64'(src_ip), 64'hC0A80102);
      check("bcast_req op const", 64'(arp_rx_op), 64'd1);

      build(BOARD_MAC, 48'h020000000002, 32'hC0A80103, 16'h0002, BOARD_IP); add_fcs(1'b0);
      run_frame("ucast_rep", frm.size(), 4);
      check("ucast_rep ip const", 64'(src_ip), 64'hC0A80103);
      check("ucast_rep op const", 64'(arp_rx_op), 64'd0);

      build('1, 48'h0A0B0C0D0E0F, 32'hC0A80105, 16'h0001, 32'hC0A8010B); add_fcs(1'b0);
      run_frame("bad_tpa", frm.size(), 4);
      build('1, 48'h0A0B0C0D0E0F, 32'hC0A80105, 16'h0001, BOARD_IP); frm[21] = 8'h00; add_fcs(1'b0);
      run_frame("bad_etype", frm.size(), 4);
      build('1, 48'h0A0B0C0D0E0F, 32'hC0A80105, 16'h0003, BOARD_IP); add_fcs(1'b0);
      run_frame("bad_oper", frm.size(), 4);
      build(48'h001122334456, 48'h0A0B0C0D0E0F, 32'hC0A80105, 16'h0001, BOARD_IP); add_fcs(1'b0);
      run_frame("bad_dest", frm.size(), 4);
      check("rejects keep ip", 64'(src_ip), 64'hC0A80103);

      build('1, 48'h0A0000000007, 32'hC0A80107, 16'h0001, BOARD_IP); add_fcs(1'b0);
      run_frame("trunc", 39, 0);
      build(BOARD_MAC, 48'h0A0000000008, 32'hC0A80108, 16'h0002, BOARD_IP); add_fcs(1'b0);
      run_frame("after_trunc", frm.size(), 4);

      build('1, 48'h0A0000000009, 32'hC0A80109, 16'h0001, BOARD_IP); add_fcs(1'b1);
      run_frame("fcs_flip", frm.size(), 4);

      // Reset asserted mid-SHA and released while the frame is still arriving.
      build('1, 48'h0A000000000A, 32'hC0A8010C, 16'h0001, BOARD_IP); add_fcs(1'b0);
      pulses.delete();
      for (int i = 0; i < frm.size(); i++) begin
         @(posedge clk); #1;
         gmii_rx_dv = 1'b1;
         gmii_rxd   = frm[i];
         if (i == 32) rst_n = 1'b0;
         if (i == 34) begin
            check("midreset done", 64'(arp_rx_done), 64'd0);
            check("midreset mac", 64'(src_mac), 64'd0);
            rst_n = 1'b1;
         end
      end
      @(posedge clk); #1;
      gmii_rx_dv = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      exp_op = 1'b0; exp_mac = '0; exp_ip = '0;
      check("postreset pulses", 64'(pulses.size()), 64'd0);
      check("postreset op", 64'(arp_rx_op), 64'd0);
      check("postreset mac", 64'(src_mac), 64'd0);
      check("postreset ip", 64'(src_ip), 64'd0);
      $display("frame reset_mid: pulses=%0d mac=%h ip=%h", pulses.size(), src_mac, src_ip);

      build('1, 48'h0A000000000B, 32'hC0A8010D, 16'h0002, BOARD_IP); add_fcs(1'b0);
      run_frame("after_reset", frm.size(), 4);

      for (int r = 0; r < 24; r++) begin
         sha = {16'($urandom), 32'($urandom)};
         spa = $urandom;
         v   = $urandom_range(8, 0);
         build(($urandom_range(1, 0) == 1) ? 48'hFFFFFFFFFFFF : BOARD_MAC, sha, spa,
               16'($urandom_range(2, 1)), BOARD_IP);
         case (v)
            3: frm[46 + $urandom_range(3, 0)] ^= 8'($urandom_range(255, 1));
            4: frm[20 + $urandom_range(1, 0)] ^= 8'($urandom_range(255, 1));
            5: frm[29] = 8'($urandom_range(255, 3));
            6: frm[8 + $urandom_range(5, 0)] ^= 8'($urandom_range(255, 1));
            7: frm[22 + $urandom_range(5, 0)] ^= 8'($urandom_range(255, 1));
            default: ;
         endcase
         add_fcs(v == 8);
         run_frame($sformatf("rand%0d_v%0d", r, v), frm.size(), (r % 3 == 0) ? 0 : 3);
      end

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
